// File: rtl/eth_rx_frame_ctrl.sv
// GMII receive frame controller: preamble/SFD detection, destination MAC filtering,
// forwarding of accepted frames with sof/eof/err markers, and good/drop frame counters.
module eth_rx_frame_ctrl #(
   parameter logic [47:0] LOCAL_MAC = 48'h00_11_22_33_44_55,
   parameter int unsigned MIN_LEN   = 64,
   parameter int unsigned MAX_LEN   = 1518
) (
   input  logic        gmii_rx_clk,
   input  logic        sys_rst,
   input  logic        gmii_rx_dv,
   input  logic [7:0]  gmii_rxd,
   input  logic        rx_en,
   output logic        out_valid,
   output logic [7:0]  out_data,
   output logic        out_sof,
   output logic        out_eof,
   output logic        out_err,
   output logic [15:0] frame_cnt,
   output logic [15:0] drop_cnt,
   output logic        busy
);

   typedef enum logic [2:0] {IDLE, PRE, DST, DATA, DROP, WAIT} state_t;

   localparam logic [10:0] MIN_L = 11'(MIN_LEN);
   localparam logic [10:0] MAX_L = 11'(MAX_LEN);

   state_t      state;
   logic        dv_d;
   logic [2:0]  pre_cnt;
   logic [2:0]  idx;
   logic        match_uc;
   logic        match_bc;
   logic [10:0] len;
   logic [7:0]  hold;
   logic        held;
   logic        sof_pend;
   logic        drop_pulse;
   logic [7:0]  mac_byte;
   logic        uc_next;
   logic        bc_next;

   always_comb begin
      mac_byte = LOCAL_MAC[7:0];
      case (idx)
         3'd0:    mac_byte = LOCAL_MAC[47:40];
         3'd1:    mac_byte = LOCAL_MAC[39:32];
         3'd2:    mac_byte = LOCAL_MAC[31:24];
         3'd3:    mac_byte = LOCAL_MAC[23:16];
         3'd4:    mac_byte = LOCAL_MAC[15:8];
         default: mac_byte = LOCAL_MAC[7:0];
      endcase
      uc_next = match_uc & (gmii_rxd == mac_byte);
      bc_next = match_bc & (gmii_rxd == 8'hFF);
   end

   always_ff @(posedge gmii_rx_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state      <= IDLE;
         dv_d       <= 1'b1;
         pre_cnt    <= '0;
         idx        <= '0;
         match_uc   <= 1'b0;
         match_bc   <= 1'b0;
         len        <= '0;
         hold       <= '0;
         held       <= 1'b0;
         sof_pend   <= 1'b0;
         drop_pulse <= 1'b0;
         out_valid  <= 1'b0;
         out_data   <= '0;
         out_sof    <= 1'b0;
         out_eof    <= 1'b0;
         out_err    <= 1'b0;
         frame_cnt  <= '0;
         drop_cnt   <= '0;
         busy       <= 1'b0;
      end else begin
         dv_d       <= gmii_rx_dv;
         out_valid  <= 1'b0;
         out_data   <= '0;
         out_sof    <= 1'b0;
         out_eof    <= 1'b0;
         out_err    <= 1'b0;
         drop_pulse <= 1'b0;
         // Counters follow the registered eof / drop events by one edge.
         frame_cnt  <= frame_cnt + 16'(out_valid & out_eof & ~out_err);
         drop_cnt   <= drop_cnt + 16'(drop_pulse | (out_valid & out_eof & out_err));
         case (state)
            IDLE: begin
               if (gmii_rx_dv && !dv_d && rx_en) begin
                  busy <= 1'b1;
                  if (gmii_rxd == 8'h55) begin
                     state   <= PRE;
                     pre_cnt <= 3'd1;
                  end else begin
                     state <= WAIT;
                  end
               end
            end
            PRE: begin
               if (!gmii_rx_dv) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else if (gmii_rxd == 8'h55) begin
                  if (pre_cnt == 3'd7) state <= WAIT;
                  else pre_cnt <= pre_cnt + 3'd1;
               end else if (gmii_rxd == 8'hD5) begin
                  state    <= DST;
                  idx      <= '0;
                  match_uc <= 1'b1;
                  match_bc <= 1'b1;
               end else begin
                  state <= WAIT;
               end
            end
            DST: begin
               if (!gmii_rx_dv) begin
                  state      <= IDLE;
                  busy       <= 1'b0;
                  drop_pulse <= 1'b1;
               end else begin
                  match_uc <= uc_next;
                  match_bc <= bc_next;
                  if (idx == 3'd5) begin
                     if (uc_next || bc_next) begin
                        state    <= DATA;
                        len      <= 11'd6;
                        held     <= 1'b0;
                        sof_pend <= 1'b1;
                     end else begin
                        state      <= DROP;
                        drop_pulse <= 1'b1;
                     end
                  end else begin
                     idx <= idx + 3'd1;
                  end
               end
            end
            DATA: begin
               if (!gmii_rx_dv) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  if (held) begin
                     out_valid <= 1'b1;
                     out_data  <= hold;
                     out_sof   <= sof_pend;
                     out_eof   <= 1'b1;
                     out_err   <= (len < MIN_L);
                  end else begin
                     drop_pulse <= 1'b1;
                  end
               end else if (len == MAX_L) begin
                  // Oversize: the new byte is discarded and the held byte closes the frame.
                  state     <= WAIT;
                  out_valid <= held;
                  out_data  <= hold;
                  out_sof   <= held & sof_pend;
                  out_eof   <= held;
                  out_err   <= held;
               end else begin
                  hold <= gmii_rxd;
                  len  <= len + 11'd1;
                  held <= 1'b1;
                  if (held) begin
                     out_valid <= 1'b1;
                     out_data  <= hold;
                     out_sof   <= sof_pend;
                     sof_pend  <= 1'b0;
                  end
               end
            end
            DROP, WAIT: begin
               if (!gmii_rx_dv) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_eth_rx_frame_ctrl.sv
// Scoreboard bench for eth_rx_frame_ctrl: expected bytes are queued as frames are
// driven and checked by a monitor on the falling edge; counters checked per scenario.
module tb_eth_rx_frame_ctrl;

   localparam logic [47:0] MAC   = 48'h00_11_22_33_44_55;
   localparam logic [47:0] BCAST = 48'hFF_FF_FF_FF_FF_FF;
   localparam int MIN_LEN = 64;
   localparam int MAX_LEN = 1518;

   logic        gmii_rx_clk = 1'b0;
   logic        sys_rst     = 1'b1;
   logic        gmii_rx_dv  = 1'b0;
   logic [7:0]  gmii_rxd    = '0;
   logic        rx_en       = 1'b1;
   logic        out_valid;
   logic [7:0]  out_data;
   logic        out_sof;
   logic        out_eof;
   logic        out_err;
   logic [15:0] frame_cnt;
   logic [15:0] drop_cnt;
   logic        busy;

   typedef struct {
      logic [7:0] data;
      logic       sof;
      logic       eof;
      logic       err;
   } exp_t;

   exp_t exp_q[$];
   int   tests_run    = 0;
   int   tests_failed = 0;
   int   exp_frame    = 0;
   int   exp_drop     = 0;

   eth_rx_frame_ctrl #(
      .LOCAL_MAC(MAC),
      .MIN_LEN  (MIN_LEN),
      .MAX_LEN  (MAX_LEN)
   ) dut (
      .gmii_rx_clk(gmii_rx_clk),
      .sys_rst    (sys_rst),
      .gmii_rx_dv (gmii_rx_dv),
      .gmii_rxd   (gmii_rxd),
      .rx_en      (rx_en),
      .out_valid  (out_valid),
      .out_data   (out_data),
      .out_sof    (out_sof),
      .out_eof    (out_eof),
      .out_err    (out_err),
      .frame_cnt  (frame_cnt),
      .drop_cnt   (drop_cnt),
      .busy       (busy)
   );

   always #4 gmii_rx_clk = ~gmii_rx_clk;

   // Output monitor: every forwarded byte must match the head of the scoreboard.
   always @(negedge gmii_rx_clk) begin
      if (!sys_rst) begin
         if (out_valid) begin
            tests_run++;
            if (exp_q.size() == 0) begin
               tests_failed++;
               $display("FAIL unexpected_output: data=%h sof=%b eof=%b err=%b, queue empty",
                        out_data, out_sof, out_eof, out_err);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               if ({out_data, out_sof, out_eof, out_err} !== {e.data, e.sof, e.eof, e.err}) begin
                  tests_failed++;
                  $display("FAIL out_byte: got data=%h sof=%b eof=%b err=%b, want data=%h sof=%b eof=%b err=%b",
                           out_data, out_sof, out_eof, out_err, e.data, e.sof, e.eof, e.err);
               end
            end
         end else if (out_sof || out_eof || out_err) begin
            tests_run++;
            tests_failed++;
            $display("FAIL flags_without_valid: sof=%b eof=%b err=%b, want 0", out_sof, out_eof, out_err);
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed + 1);
      $fatal(1, "watchdog");
   end

   task automatic drive(input logic dv, input logic [7:0] d);
      gmii_rx_dv = dv;
      gmii_rxd   = d;
      @(posedge gmii_rx_clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 8'h00);
   endtask

   task automatic send_hdr(input logic [47:0] dst);
      for (int i = 0; i < 7; i++) drive(1'b1, 8'h55);
      drive(1'b1, 8'hD5);
      for (int i = 0; i < 6; i++) drive(1'b1, dst[47-8*i -: 8]);
   endtask

   // Drives a full frame with a ramp payload of n bytes and queues the expected output.
   task automatic send_frame(input logic [47:0] dst, input int n, input int ifg);
      bit acc;
      bit bad;
      int nout;
      acc  = (dst == MAC) || (dst == BCAST);
      nout = (n > MAX_LEN - 6) ? MAX_LEN - 6 : n;
      bad  = (n > MAX_LEN - 6) || (n + 6 < MIN_LEN);
      if (!acc || nout == 0) begin
         exp_drop++;
      end else begin
         for (int j = 0; j < nout; j++) begin
            exp_t e;
            e.data = 8'(j);
            e.sof  = (j == 0);
            e.eof  = (j == nout - 1);
            e.err  = (j == nout - 1) && bad;
            exp_q.push_back(e);
         end
         if (bad) exp_drop++;
         else exp_frame++;
      end
      send_hdr(dst);
      for (int j = 0; j < n; j++) drive(1'b1, 8'(j));
      idle(ifg);
   endtask

   task automatic test_reset;
      @(negedge gmii_rx_clk);
      tests_run++;
      if ({out_valid, out_data, out_sof, out_eof, out_err} !== 12'h000) begin
         tests_failed++;
         $display("FAIL reset_outputs: got valid=%b data=%h sof=%b eof=%b err=%b, want all 0",
                  out_valid, out_data, out_sof, out_eof, out_err);
      end
      tests_run++;
      if ({frame_cnt, drop_cnt} !== 32'h0) begin
         tests_failed++;
         $display("FAIL reset_counters: got frame=%0d drop=%0d, want 0 0", frame_cnt, drop_cnt);
      end
      tests_run++;
      if (busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_busy: got %b, want 0", busy);
      end
      @(posedge gmii_rx_clk);
      #1;
      sys_rst = 1'b0;
      idle(2);
   endtask

   task automatic check_end(input string name);
      for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(negedge gmii_rx_clk);
      idle(3);
      tests_run++;
      if (exp_q.size() != 0) begin
         tests_failed++;
         $display("FAIL %s_missing_bytes: got %0d bytes outstanding, want 0", name, exp_q.size());
         exp_q.delete();
      end
      tests_run++;
      if (frame_cnt !== 16'(exp_frame)) begin
         tests_failed++;
         $display("FAIL %s_frame_cnt: got %0d, want %0d", name, frame_cnt, exp_frame);
      end
      tests_run++;
      if (drop_cnt !== 16'(exp_drop)) begin
         tests_failed++;
         $display("FAIL %s_drop_cnt: got %0d, want %0d", name, drop_cnt, exp_drop);
      end
   endtask

   task automatic test_unicast;
      send_frame(MAC, 58, 2);
      check_end("unicast");
   endtask

   task automatic test_broadcast;
      send_frame(BCAST, 100, 2);
      check_end("broadcast");
   endtask

   task automatic test_filter_miss;
      send_frame(48'h00_11_22_33_44_56, 40, 0);
      tests_run++;
      if (busy !== 1'b1) begin
         tests_failed++;
         $display("FAIL filter_miss_busy: got %b, want 1", busy);
      end
      idle(1);
      tests_run++;
      if (busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL filter_miss_busy_after: got %b, want 0", busy);
      end
      check_end("filter_miss");
   endtask

   task automatic test_runt_oversize;
      send_frame(MAC, 24, 2);
      check_end("runt30");
      send_frame(MAC, 1, 2);
      check_end("runt7");
      send_frame(MAC, 0, 2);
      check_end("dst_only");
      send_frame(MAC, 1594, 0);
      tests_run++;
      if (busy !== 1'b1) begin
         tests_failed++;
         $display("FAIL oversize_wait_busy: got %b, want 1", busy);
      end
      idle(1);
      check_end("oversize");
   endtask

   task automatic test_preamble_errors;
      for (int i = 0; i < 2; i++) drive(1'b1, 8'h55);
      drive(1'b1, 8'h5A);
      for (int i = 0; i < 4; i++) drive(1'b1, 8'h55);
      drive(1'b1, 8'hD5);
      for (int i = 0; i < 6; i++) drive(1'b1, MAC[47-8*i -: 8]);
      for (int j = 0; j < 30; j++) drive(1'b1, 8'(j));
      tests_run++;
      if (busy !== 1'b1) begin
         tests_failed++;
         $display("FAIL bad_preamble_busy: got %b, want 1", busy);
      end
      idle(2);
      check_end("bad_preamble");
      for (int i = 0; i < 8; i++) drive(1'b1, 8'h55);
      drive(1'b1, 8'hD5);
      for (int i = 0; i < 6; i++) drive(1'b1, MAC[47-8*i -: 8]);
      for (int j = 0; j < 60; j++) drive(1'b1, 8'(j));
      idle(2);
      check_end("long_preamble");
      rx_en = 1'b0;
      for (int i = 0; i < 3; i++) drive(1'b1, 8'h55);
      rx_en = 1'b1;
      send_hdr(MAC);
      for (int j = 0; j < 60; j++) drive(1'b1, 8'(j));
      tests_run++;
      if (busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL rx_en_ignored_busy: got %b, want 0", busy);
      end
      idle(2);
      check_end("rx_en_ignored");
   endtask

   task automatic test_reset_midframe;
      for (int j = 0; j < 18; j++) begin
         exp_t e;
         e.data = 8'(j);
         e.sof  = (j == 0);
         e.eof  = 1'b0;
         e.err  = 1'b0;
         exp_q.push_back(e);
      end
      send_hdr(MAC);
      for (int j = 0; j < 20; j++) drive(1'b1, 8'(j));
      sys_rst = 1'b1;
      drive(1'b1, 8'd20);
      drive(1'b1, 8'd21);
      tests_run++;
      if ({out_valid, out_sof, out_eof, out_err, busy} !== 5'b0) begin
         tests_failed++;
         $display("FAIL midreset_outputs: got valid=%b sof=%b eof=%b err=%b busy=%b, want 0",
                  out_valid, out_sof, out_eof, out_err, busy);
      end
      tests_run++;
      if (exp_q.size() != 0) begin
         tests_failed++;
         $display("FAIL midreset_pre_bytes: got %0d bytes outstanding, want 0", exp_q.size());
         exp_q.delete();
      end
      exp_frame = 0;
      exp_drop  = 0;
      sys_rst = 1'b0;
      for (int j = 22; j < 50; j++) drive(1'b1, 8'(j));
      tests_run++;
      if (busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL midreset_ignore_busy: got %b, want 0", busy);
      end
      idle(3);
      check_end("midreset");
      send_frame(MAC, 58, 3);
      check_end("after_reset");
   endtask

   task automatic test_back_to_back;
      send_frame(MAC, 58, 1);
      send_frame(MAC, 40, 1);
      send_frame(BCAST, 10, 1);
      send_frame(MAC, 70, 1);
      check_end("back_to_back");
   endtask

   initial begin
      idle(3);
      test_reset;
      test_unicast;
      test_broadcast;
      test_filter_miss;
      test_runt_oversize;
      test_preamble_errors;
      test_reset_midframe;
      test_back_to_back;
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
